// File: rtl/serial_port_pkg.sv
// Shared definitions for the serial_port_slave_fifo Wishbone slave.
// Contents: register indices (adr_i[3:2]), STATUS/CTRL bit positions and the bus FSM states.
package serial_port_pkg;

  // Register indices decoded from adr_i[3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // STATUS bit positions ([7:0] rx_count, [15:8] tx_free)
  localparam int unsigned ST_RX_EMPTY   = 16;
  localparam int unsigned ST_TX_FULL    = 17;
  localparam int unsigned ST_RX_OVERRUN = 18;

  // CTRL bit positions
  localparam int unsigned CTRL_BLOCK  = 0;
  localparam int unsigned CTRL_RX_IRQ = 1;
  localparam int unsigned CTRL_TX_IRQ = 2;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWaitRd = 2'd1,
    StWaitWr = 2'd2
  } state_e;

endpackage

// File: rtl/serial_fifo.sv
// Synchronous FIFO with 2**DEPTH_LOG2 usable entries (wrap-bit pointers).
// Ports:
//   clk_bus, rst_bus   clock, asynchronous active-low reset
//   push_i, wdata_i    write request (ignored when full)
//   pop_i, rdata_o     read request (ignored when empty), combinational head data
//   full_o, empty_o    status flags
//   count_o            occupancy, 0..2**DEPTH_LOG2
module serial_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned DATA_W     = 8
) (
  input  logic                clk_bus,
  input  logic                rst_bus,
  input  logic                push_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                pop_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [DEPTH_LOG2:0] count_o
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PtrOne = 1;

  logic [DATA_W-1:0]   mem_q [Depth];
  logic [DEPTH_LOG2:0] head_q, tail_q;
  logic                do_push, do_pop;

  assign empty_o = (head_q == tail_q);
  assign full_o  = (head_q[DEPTH_LOG2-1:0] == tail_q[DEPTH_LOG2-1:0]) &&
                   (head_q[DEPTH_LOG2] != tail_q[DEPTH_LOG2]);
  assign count_o = tail_q - head_q;
  assign rdata_o = mem_q[head_q[DEPTH_LOG2-1:0]];

  // Fullness/emptiness are pre-update values, so a pop never frees room for a push in the same cycle
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_bus or negedge rst_bus) begin
    if (!rst_bus) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[tail_q[DEPTH_LOG2-1:0]] <= wdata_i;
        tail_q <= tail_q + PtrOne;
      end
      if (do_pop) begin
        head_q <= head_q + PtrOne;
      end
    end
  end

endmodule

// File: rtl/serial_port_slave_fifo.sv
// Pipelined 32-bit Wishbone slave buffering traffic between the bus and a UART core.
// Optional feature macro: SERIAL_PORT_SLAVE_IRQ_EN (registered irq_o, CTRL[2:1] stored).
// Ports:
//   clk_bus, rst_bus              clock, asynchronous active-low reset
//   dat_i/dat_o/adr_i/cyc_i/stb_i/we_i/sel_i   Wishbone request/read data
//   ack_o/err_o/rty_o             registered one-cycle terminations
//   stall_o                       high while a blocking access is waiting
//   rx_data_i, rx_valid_i         characters from the UART core (no backpressure)
//   tx_data_o, tx_valid_o, tx_ready_i   characters to the UART core
//   irq_o                         interrupt request
module serial_port_slave_fifo
  import serial_port_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned TIMEOUT    = 0
) (
  input  logic              clk_bus,
  input  logic              rst_bus,
  input  logic [31:0]       dat_i,
  output logic [31:0]       dat_o,
  input  logic [31:0]       adr_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [3:0]        sel_i,
  output logic              ack_o,
  output logic              err_o,
  output logic              rty_o,
  output logic              stall_o,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              irq_o
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  logic                rx_pop, rx_full, rx_empty;
  logic [DATA_W-1:0]   rx_rdata;
  logic [DEPTH_LOG2:0] rx_count;
  logic                tx_push, tx_pop, tx_full, tx_empty;
  logic [DATA_W-1:0]   tx_wdata;
  logic [DEPTH_LOG2:0] tx_count;

  state_e            state_q, state_d;
  logic              ack_q, ack_d, err_q, err_d, rty_q, rty_d;
  logic [31:0]       dat_q, dat_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic              ovr_q, ovr_set, ovr_clr;
  logic [31:0]       wait_cnt_q, wait_cnt_d;
  logic              req, timeout_hit;
  logic [31:0]       status;
  logic              unused_sig;

  serial_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .DATA_W    (DATA_W)
  ) u_rx_fifo (
    .clk_bus(clk_bus),
    .rst_bus(rst_bus),
    .push_i (rx_valid_i),
    .wdata_i(rx_data_i),
    .pop_i  (rx_pop),
    .rdata_o(rx_rdata),
    .full_o (rx_full),
    .empty_o(rx_empty),
    .count_o(rx_count)
  );

  serial_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .DATA_W    (DATA_W)
  ) u_tx_fifo (
    .clk_bus(clk_bus),
    .rst_bus(rst_bus),
    .push_i (tx_push),
    .wdata_i(tx_wdata),
    .pop_i  (tx_pop),
    .rdata_o(tx_data_o),
    .full_o (tx_full),
    .empty_o(tx_empty),
    .count_o(tx_count)
  );

  assign tx_valid_o = ~tx_empty;
  assign tx_pop     = tx_valid_o & tx_ready_i;

  assign stall_o = (state_q != StIdle);
  assign req     = cyc_i & stb_i & ~stall_o;
  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign rty_o   = rty_q;
  assign dat_o   = dat_q;

  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == TIMEOUT - 1);
  assign ovr_set     = rx_valid_i & rx_full;

  always_comb begin
    status                = '0;
    status[7:0]           = 8'(rx_count);
    status[15:8]          = 8'(Depth) - 8'(tx_count);
    status[ST_RX_EMPTY]   = rx_empty;
    status[ST_TX_FULL]    = tx_full;
    status[ST_RX_OVERRUN] = ovr_q;
  end

  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rty_d      = 1'b0;
    dat_d      = '0;
    wr_data_d  = wr_data_q;
    ctrl_d     = ctrl_q;
    ovr_clr    = 1'b0;
    wait_cnt_d = '0;
    rx_pop     = 1'b0;
    tx_push    = 1'b0;
    tx_wdata   = dat_i[DATA_W-1:0];
    unique case (state_q)
      StIdle: begin
        if (req) begin
          unique case (adr_i[3:2])
            REG_DATA: begin
              if (!we_i) begin
                if (!rx_empty) begin
                  rx_pop = 1'b1;
                  ack_d  = 1'b1;
                  dat_d  = 32'(rx_rdata);
                end else if (ctrl_q[CTRL_BLOCK]) begin
                  state_d = StWaitRd;
                end else begin
                  rty_d = 1'b1;
                end
              end else if (!sel_i[0]) begin
                ack_d = 1'b1;
              end else if (!tx_full) begin
                tx_push = 1'b1;
                ack_d   = 1'b1;
              end else if (ctrl_q[CTRL_BLOCK]) begin
                state_d   = StWaitWr;
                wr_data_d = dat_i[DATA_W-1:0];
              end else begin
                rty_d = 1'b1;
              end
            end
            REG_STATUS: begin
              if (we_i) begin
                err_d = 1'b1;
              end else begin
                ack_d   = 1'b1;
                dat_d   = status;
                ovr_clr = 1'b1;
              end
            end
            REG_CTRL: begin
              ack_d = 1'b1;
              if (we_i) begin
                ctrl_d[CTRL_BLOCK] = dat_i[CTRL_BLOCK];
`ifdef SERIAL_PORT_SLAVE_IRQ_EN
                ctrl_d[CTRL_RX_IRQ] = dat_i[CTRL_RX_IRQ];
                ctrl_d[CTRL_TX_IRQ] = dat_i[CTRL_TX_IRQ];
`endif
              end else begin
                dat_d = 32'(ctrl_q);
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      StWaitRd: begin
        if (!cyc_i) begin
          state_d = StIdle;
        end else if (!rx_empty) begin
          rx_pop  = 1'b1;
          ack_d   = 1'b1;
          dat_d   = 32'(rx_rdata);
          state_d = StIdle;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
      StWaitWr: begin
        tx_wdata = wr_data_q;
        if (!cyc_i) begin
          state_d = StIdle;
        end else if (!tx_full) begin
          tx_push = 1'b1;
          ack_d   = 1'b1;
          state_d = StIdle;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_bus or negedge rst_bus) begin
    if (!rst_bus) begin
      state_q    <= StIdle;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rty_q      <= 1'b0;
      dat_q      <= '0;
      wr_data_q  <= '0;
      ctrl_q     <= '0;
      ovr_q      <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rty_q      <= rty_d;
      dat_q      <= dat_d;
      wr_data_q  <= wr_data_d;
      ctrl_q     <= ctrl_d;
      // A new overrun wins over the clear so the event is never lost
      ovr_q      <= ovr_set | (ovr_q & ~ovr_clr);
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef SERIAL_PORT_SLAVE_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk_bus or negedge rst_bus) begin
    if (!rst_bus) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (ctrl_q[CTRL_RX_IRQ] & ~rx_empty) | (ctrl_q[CTRL_TX_IRQ] & tx_empty) | ovr_q;
    end
  end
  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  assign unused_sig = ^{adr_i[31:4], adr_i[1:0], dat_i[31:DATA_W], sel_i[3:1]};

endmodule

// File: tb/tb_serial_port_slave_fifo.sv
// Scoreboard bench for serial_port_slave_fifo: requests push expected terminations,
// independent monitors compare bus terminations and TX characters.
module tb_serial_port_slave_fifo;
  import serial_port_pkg::*;

  localparam int unsigned DepthLog2 = 4;
  localparam int unsigned DataW     = 8;
  localparam int unsigned Timeout   = 8;
  localparam logic [2:0] TermAck = 3'b100;
  localparam logic [2:0] TermErr = 3'b010;
  localparam logic [2:0] TermRty = 3'b001;
`ifdef SERIAL_PORT_SLAVE_IRQ_EN
  localparam bit IrqEn = 1'b1;
`else
  localparam bit IrqEn = 1'b0;
`endif

  logic             clk_bus, rst_bus;
  logic [31:0]      dat_i, dat_o, adr_i;
  logic             cyc_i, stb_i, we_i;
  logic [3:0]       sel_i;
  logic             ack_o, err_o, rty_o, stall_o;
  logic [DataW-1:0] rx_data_i, tx_data_o;
  logic             rx_valid_i, tx_valid_o, tx_ready_i, irq_o;

  typedef struct {
    logic [2:0]  term;
    logic [31:0] dat;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] tx_exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic        saw_stall = 1'b0;
  logic        saw_irq = 1'b0;

  serial_port_slave_fifo #(
    .DEPTH_LOG2(DepthLog2),
    .DATA_W    (DataW),
    .TIMEOUT   (Timeout)
  ) u_dut (
    .clk_bus   (clk_bus),
    .rst_bus   (rst_bus),
    .dat_i     (dat_i),
    .dat_o     (dat_o),
    .adr_i     (adr_i),
    .cyc_i     (cyc_i),
    .stb_i     (stb_i),
    .we_i      (we_i),
    .sel_i     (sel_i),
    .ack_o     (ack_o),
    .err_o     (err_o),
    .rty_o     (rty_o),
    .stall_o   (stall_o),
    .rx_data_i (rx_data_i),
    .rx_valid_i(rx_valid_i),
    .tx_data_o (tx_data_o),
    .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i),
    .irq_o     (irq_o)
  );

  initial clk_bus = 1'b0;
  always #5 clk_bus = ~clk_bus;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Bus termination monitor
  always @(negedge clk_bus) begin
    if (stall_o) saw_stall = 1'b1;
    if (irq_o) saw_irq = 1'b1;
    if (rst_bus && (ack_o || err_o || rty_o)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_term actual=%b required=none", {ack_o, err_o, rty_o});
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_term"}, 32'({ack_o, err_o, rty_o}), 32'(e.term));
        chk({e.name, "_dat"}, dat_o, e.dat);
      end
    end
  end

  // TX character monitor
  always @(negedge clk_bus) begin
    if (rst_bus && tx_valid_o && tx_ready_i) begin
      if (tx_exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_tx actual=%h required=none", tx_data_o);
      end else begin
        chk("tx_data", 32'(tx_data_o), tx_exp_q.pop_front());
      end
    end
  end

  // abort_after != 0: drop cyc_i that many cycles after acceptance, expecting no termination
  task automatic bus_req(input logic we, input logic [1:0] reg_idx, input logic [31:0] wdat,
                         input logic [3:0] sel, input logic [2:0] term, input logic [31:0] edat,
                         input string name, input int abort_after);
    exp_t e;
    bit   done;
    @(posedge clk_bus); #1;
    cyc_i = 1'b1;
    stb_i = 1'b1;
    we_i  = we;
    adr_i = {28'h0, reg_idx, 2'b00};
    dat_i = wdat;
    sel_i = sel;
    if (abort_after == 0) begin
      e.term = term;
      e.dat  = edat;
      e.name = name;
      exp_q.push_back(e);
    end
    @(posedge clk_bus); #1;
    stb_i = 1'b0;
    we_i  = 1'b0;
    dat_i = '0;
    if (abort_after != 0) begin
      repeat (abort_after - 1) @(posedge clk_bus);
      #1;
      cyc_i = 1'b0;
      @(posedge clk_bus); #1;
      return;
    end
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (ack_o || err_o || rty_o) done = 1'b1;
      else begin
        @(posedge clk_bus); #1;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_no_term actual=none required=%b", name, term);
      void'(exp_q.pop_back());
    end
    cyc_i = 1'b0;
  endtask

  task automatic rx_burst(input logic [DataW-1:0] first, input int n);
    @(posedge clk_bus); #1;
    for (int i = 0; i < n; i++) begin
      rx_valid_i = 1'b1;
      rx_data_i  = first + DataW'(i);
      @(posedge clk_bus); #1;
    end
    rx_valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst_bus    = 1'b0;
    dat_i      = '0;
    adr_i      = '0;
    cyc_i      = 1'b0;
    stb_i      = 1'b0;
    we_i       = 1'b0;
    sel_i      = '0;
    rx_data_i  = '0;
    rx_valid_i = 1'b0;
    tx_ready_i = 1'b0;
    repeat (3) @(posedge clk_bus);
    #1;
    chk("rst_ack", 32'(ack_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_rty", 32'(rty_o), 0);
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_tx_valid", 32'(tx_valid_o), 0);
    chk("rst_irq", 32'(irq_o), 0);
    rst_bus = 1'b1;
    @(posedge clk_bus); #1;

    // Basic RX path
    rx_burst(8'h41, 2);
    bus_req(1'b0, REG_DATA, 0, 4'hF, TermAck, 32'h41, "rd_41", 0);
    bus_req(1'b0, REG_DATA, 0, 4'hF, TermAck, 32'h42, "rd_42", 0);
    bus_req(1'b0, REG_STATUS, 0, 4'hF, TermAck, 32'h0001_1000, "status_empty", 0);

    // Non-blocking read of empty RX
    saw_stall = 1'b0;
    bus_req(1'b0, REG_DATA, 0, 4'hF, TermRty, 32'h0, "rd_empty_rty", 0);
    chk("no_stall_nonblock", 32'(saw_stall), 0);

    // Blocking read satisfied by a later RX character
    bus_req(1'b1, REG_CTRL, 32'h1, 4'hF, TermAck, 32'h0, "ctrl_wr_block", 0);
    bus_req(1'b0, REG_CTRL, 0, 4'hF, TermAck, 32'h1, "ctrl_rd_block", 0);
    saw_stall = 1'b0;
    fork
      bus_req(1'b0, REG_DATA, 0, 4'hF, TermAck, 32'h55, "rd_blocking", 0);
      begin
        repeat (3) @(posedge clk_bus);
        rx_burst(8'h55, 1);
      end
    join
    chk("stall_blocking", 32'(saw_stall), 1);

    // Abort by dropping cyc_i
    bus_req(1'b0, REG_DATA, 0, 4'hF, TermAck, 32'h0, "rd_abort", 3);
    bus_req(1'b0, REG_STATUS, 0, 4'hF, TermAck, 32'h0001_1000, "status_after_abort", 0);

    // TX fill, timeout and retry
    bus_req(1'b1, REG_DATA, 32'hEE, 4'hE, TermAck, 32'h0, "wr_nosel", 0);
    for (int i = 0; i < 16; i++) begin
      tx_exp_q.push_back(32'h10 + 32'(i));
      bus_req(1'b1, REG_DATA, 32'h10 + 32'(i), 4'h1, TermAck, 32'h0, "wr_fill", 0);
    end
    bus_req(1'b0, REG_STATUS, 0, 4'hF, TermAck, 32'h0003_0000, "status_tx_full", 0);
    bus_req(1'b1, REG_DATA, 32'hAA, 4'h1, TermErr, 32'h0, "wr_timeout", 0);
    bus_req(1'b0, REG_STATUS, 0, 4'hF, TermAck, 32'h0003_0000, "status_after_to", 0);
    bus_req(1'b1, REG_CTRL, 32'h0, 4'hF, TermAck, 32'h0, "ctrl_wr_nonblock", 0);
    bus_req(1'b1, REG_DATA, 32'hAB, 4'h1, TermRty, 32'h0, "wr_full_rty", 0);
    bus_req(1'b1, REG_CTRL, 32'h1, 4'hF, TermAck, 32'h0, "ctrl_wr_block2", 0);

    // Blocking write completes once the UART drains a character
    tx_exp_q.push_back(32'h77);
    fork
      bus_req(1'b1, REG_DATA, 32'h77, 4'h1, TermAck, 32'h0, "wr_blocking", 0);
      begin
        repeat (3) @(posedge clk_bus);
        #1;
        tx_ready_i = 1'b1;
      end
    join
    for (int i = 0; i < 40 && tx_valid_o; i++) begin
      @(posedge clk_bus); #1;
    end
    chk("tx_drained", 32'(tx_valid_o), 0);
    chk("tx_exp_empty", 32'(tx_exp_q.size()), 0);

    // Simultaneous bus push and UART pop
    tx_ready_i = 1'b0;
    tx_exp_q.push_back(32'h81);
    bus_req(1'b1, REG_DATA, 32'h81, 4'h1, TermAck, 32'h0, "wr_81", 0);
    tx_exp_q.push_back(32'h82);
    fork
      bus_req(1'b1, REG_DATA, 32'h82, 4'h1, TermAck, 32'h0, "wr_82_simul", 0);
      begin
        @(posedge clk_bus); #1;
        tx_ready_i = 1'b1;
        @(posedge clk_bus); #1;
        tx_ready_i = 1'b0;
      end
    join
    bus_req(1'b0, REG_STATUS, 0, 4'hF, TermAck, 32'h0001_0F00, "status_simul", 0);
    tx_ready_i = 1'b1;
    repeat (3) @(posedge clk_bus);
    #1;
    chk("tx_exp_empty2", 32'(tx_exp_q.size()), 0);

    // RX overrun: 17th character dropped, sticky flag cleared by STATUS read
    rx_burst(8'h60, 17);
    bus_req(1'b0, REG_STATUS, 0, 4'hF, TermAck, 32'h0004_1010, "status_overrun", 0);
    bus_req(1'b0, REG_STATUS, 0, 4'hF, TermAck, 32'h0000_1010, "status_ovr_clr", 0);
    for (int i = 0; i < 16; i++) begin
      bus_req(1'b0, REG_DATA, 0, 4'hF, TermAck, 32'h60 + 32'(i), "rd_full", 0);
    end
    bus_req(1'b0, REG_STATUS, 0, 4'hF, TermAck, 32'h0001_1000, "status_drained", 0);

    // Error terminations
    bus_req(1'b0, 2'd3, 0, 4'hF, TermErr, 32'h0, "reg3_rd", 0);
    bus_req(1'b1, 2'd3, 32'h1, 4'hF, TermErr, 32'h0, "reg3_wr", 0);
    bus_req(1'b1, REG_STATUS, 32'hFFFF_FFFF, 4'hF, TermErr, 32'h0, "status_wr", 0);

    // CTRL readback and interrupt
    bus_req(1'b1, REG_CTRL, 32'h7, 4'hF, TermAck, 32'h0, "ctrl_wr_7", 0);
    bus_req(1'b0, REG_CTRL, 0, 4'hF, TermAck, IrqEn ? 32'h7 : 32'h1, "ctrl_rd_7", 0);
    bus_req(1'b1, REG_CTRL, 32'h3, 4'hF, TermAck, 32'h0, "ctrl_wr_3", 0);
    repeat (2) @(posedge clk_bus);
    #1;
    chk("irq_idle", 32'(irq_o), 0);
    rx_burst(8'h5A, 1);
    repeat (2) @(posedge clk_bus);
    #1;
    chk("irq_rx", 32'(irq_o), IrqEn ? 32'h1 : 32'h0);
    bus_req(1'b0, REG_DATA, 0, 4'hF, TermAck, 32'h5A, "rd_irq", 0);
    repeat (2) @(posedge clk_bus);
    #1;
    chk("irq_cleared", 32'(irq_o), 0);
    if (!IrqEn) chk("irq_never", 32'(saw_irq), 0);

    repeat (2) @(posedge clk_bus);
    #1;
    chk("exp_q_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
